mem_bus_arbiter: RTL

- Two-master, one-slave arbiter for the memory-mapped bus driven by the VProc RISC-V wrapper.
- Shares one memory slave between requesters. Typical pairing is the wrapper's instruction port (master 0) and data port (master 1), or two processor nodes.
- Masters follow waitrequest rules: each holds address, controls and data stable until the cycle where its request is seen with waitrequest low.
- Round-robin with a configurable back-to-back allowance so one master cannot starve the other.

---
 rtl/mem_bus_pkg.sv | 19 +
 rtl/mem_bus_arbiter_rr_arb2.sv | 20 ++
 rtl/mem_bus_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared constants and state encoding for the memory bus fabric.
// Ports: none (package only).
package mem_bus_pkg;

   localparam int BUS_ADDR_W = 32;
   localparam int BUS_DATA_W = 32;
   localparam int HOLD_CNT_W = 4;

   localparam logic [HOLD_CNT_W-1:0] HOLD_SAT = '1;

   // Grant states are one-hot in the low bits so the grant
   // port is a direct copy of the state register.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_GNT0 = 2'b01,
      ST_GNT1 = 2'b10
   } arb_state_t;

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// rr_arb2: two-requester round-robin picker.
// Ports: i_req (request pair), i_last (previous owner), o_gnt (one-hot pick).
module rr_arb2 (
   input  logic [1:0] i_req,
   input  logic       i_last,
   output logic [1:0] o_gnt
);

   // On a tie the requester that did not own the bus last wins.
   always_comb begin
      o_gnt = 2'b00;
      unique case (i_req)
         2'b01:   o_gnt = 2'b01;
         2'b10:   o_gnt = 2'b10;
         2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
         default: o_gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master, one-slave round-robin bus arbiter.
// Ports: clk/reset, m0_*/m1_* master buses, s_* slave bus, grant owner.
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W   = BUS_ADDR_W,
   parameter int DATA_W   = BUS_DATA_W,
   parameter int MAX_HOLD = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   input  logic              m0_read,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_waitrequest,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   input  logic              m1_read,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_waitrequest,
   output logic [ADDR_W-1:0] s_address,
   output logic              s_write,
   output logic [DATA_W-1:0] s_writedata,
   output logic [DATA_W/8-1:0] s_byteenable,
   output logic              s_read,
   input  logic [DATA_W-1:0] s_readdata,
   input  logic              s_waitrequest,
   output logic [1:0]        grant
);

   localparam int CW = HOLD_CNT_W + 1;
   localparam logic [CW-1:0] LP_LIMIT = CW'(MAX_HOLD);
   localparam logic [CW-1:0] LP_ONE   = CW'(1);
   localparam logic [HOLD_CNT_W-1:0] LP_INC = HOLD_CNT_W'(1);

   arb_state_t            r_state;
   logic                  r_last;
   logic [HOLD_CNT_W-1:0] r_hold;

   logic                  w_req0;
   logic                  w_req1;
   logic                  w_own_idx;
   logic                  w_own_req;
   logic                  w_oth_req;
   logic                  w_done;
   logic                  w_hold_lim;
   logic [CW-1:0]         w_hold_nx;
   logic [HOLD_CNT_W-1:0] w_hold_inc;
   logic [1:0]            w_pick;
   arb_state_t            w_oth_st;

   assign w_req0    = m0_read | m0_write;
   assign w_req1    = m1_read | m1_write;
   assign w_own_idx = (r_state == ST_GNT1);
   assign w_own_req = w_own_idx ? w_req1 : w_req0;
   assign w_oth_req = w_own_idx ? w_req0 : w_req1;
   assign w_oth_st  = w_own_idx ? ST_GNT0 : ST_GNT1;

   assign w_done = (r_state != ST_IDLE)
                 & w_own_req & ~s_waitrequest;

   // Limit test uses one extra bit so a saturated count
   // still compares correctly against MAX_HOLD.
   assign w_hold_nx  = {1'b0, r_hold} + LP_ONE;
   assign w_hold_lim = (w_hold_nx >= LP_LIMIT);
   assign w_hold_inc = (r_hold == HOLD_SAT) ?
                       r_hold : r_hold + LP_INC;

   rr_arb2 u_pick (
      .i_req  ({w_req1, w_req0}),
      .i_last (r_last),
      .o_gnt  (w_pick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_last  <= 1'b1;
         r_hold  <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               r_hold <= '0;
               if (w_pick[0]) begin
                  r_state <= ST_GNT0;
               end else if (w_pick[1]) begin
                  r_state <= ST_GNT1;
               end
            end
            ST_GNT0, ST_GNT1: begin
               if (w_done) begin
                  r_last <= w_own_idx;
                  r_hold <= w_hold_inc;
               end
               // A stalled owner keeps the bus: both exits need
               // either a completion or a dropped request.
               if (w_done && w_oth_req && w_hold_lim) begin
                  r_state <= w_oth_st;
                  r_hold  <= '0;
               end else if (!w_own_req) begin
                  r_state <= w_oth_req ? w_oth_st : ST_IDLE;
                  r_hold  <= '0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_hold  <= '0;
            end
         endcase
      end
   end

   assign grant = r_state;

   // Data path is purely combinational steering by owner.
   // Write wins when a master raises both strobes.
   always_comb begin
      s_address      = '0;
      s_writedata    = '0;
      s_byteenable   = '0;
      s_write        = 1'b0;
      s_read         = 1'b0;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
      m0_readdata    = '0;
      m1_readdata    = '0;
      unique case (r_state)
         ST_GNT0: begin
            s_address      = m0_address;
            s_writedata    = m0_writedata;
            s_byteenable   = m0_byteenable;
            s_write        = m0_write;
            s_read         = m0_read & ~m0_write;
            m0_waitrequest = w_req0 ? s_waitrequest : 1'b1;
            m0_readdata    = s_readdata;
         end
         ST_GNT1: begin
            s_address      = m1_address;
            s_writedata    = m1_writedata;
            s_byteenable   = m1_byteenable;
            s_write        = m1_write;
            s_read         = m1_read & ~m1_write;
            m1_waitrequest = w_req1 ? s_waitrequest : 1'b1;
            m1_readdata    = s_readdata;
         end
         default: begin
         end
      endcase
   end

endmodule
